// File: rtl/tick_timer_pkg.sv
// rtl/tick_timer_pkg.sv - shared types and default width for the tick timer
package tick_timer_pkg;

    localparam int TIMER_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/tick_timer_if.sv
// rtl/tick_timer_if.sv - control/status bundle between a timer user and tick_timer
interface tick_timer_if
    import tick_timer_pkg::*;
#(
    parameter int W = TIMER_W
);
    logic         clk_divided;
    logic [W-1:0] load_value;
    logic         mode;
    logic         start;
    logic         stop;
    logic         tick;
    logic         busy;
    logic         expire;
    logic [W-1:0] count;

    modport master (
        output clk_divided, load_value, mode, start, stop,
        input  tick, busy, expire, count
    );

    modport slave (
        input  clk_divided, load_value, mode, start, stop,
        output tick, busy, expire, count
    );
endinterface

// File: rtl/tick_timer_rise_detect.sv
// rtl/tick_timer_rise_detect.sv - rising-edge detector with combinational and registered strobes
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic pulse
);
    logic prev;

    // d is already synchronous to clk, so a single history flop suffices
    assign rise = d & ~prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= d;
            pulse <= rise;
        end
    end
endmodule

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - down-counting one-shot/periodic timer paced by the divider output
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic          clk,
    input  logic          rst,
    tick_timer_if.slave   tif
);
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] ZERO = '0;

    timer_state_t state;
    logic [W-1:0] count_r;
    logic [W-1:0] reload_r;
    logic         mode_r;
    logic         busy_r;
    logic         expire_r;
    logic         rise;
    logic         tick_r;

    rise_detect u_rise (
        .clk   (clk),
        .rst   (rst),
        .d     (tif.clk_divided),
        .rise  (rise),
        .pulse (tick_r)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count_r  <= ZERO;
            reload_r <= ZERO;
            mode_r   <= 1'b0;
            busy_r   <= 1'b0;
            expire_r <= 1'b0;
        end else begin
            expire_r <= 1'b0;
            if (tif.stop) begin
                // abort always wins, and swallows any coincident terminal tick
                state   <= IDLE;
                busy_r  <= 1'b0;
                count_r <= ZERO;
            end else if (tif.start) begin
                if (tif.load_value != ZERO) begin
                    state    <= RUN;
                    busy_r   <= 1'b1;
                    count_r  <= tif.load_value;
                    reload_r <= tif.load_value;
                    mode_r   <= tif.mode;
                end else begin
                    // a zero-length request expires immediately without running
                    state    <= IDLE;
                    busy_r   <= 1'b0;
                    count_r  <= ZERO;
                    expire_r <= 1'b1;
                end
            end else if (state == RUN && rise) begin
                if (count_r == ONE) begin
                    expire_r <= 1'b1;
                    if (mode_r) begin
                        count_r <= reload_r;
                    end else begin
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                        count_r <= ZERO;
                    end
                end else begin
                    count_r <= count_r - ONE;
                end
            end
        end
    end

    assign tif.tick   = tick_r;
    assign tif.busy   = busy_r;
    assign tif.expire = expire_r;
    assign tif.count  = count_r;
endmodule

// File: tb/tb_tick_timer.sv
// tb/tb_tick_timer.sv - self-checking bench for tick_timer
module tb_tick_timer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    tick_timer_if #(.W(16)) tif ();

    tick_timer #(.W(16)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        cd;
        logic        st;
        logic        sp;
        logic        md;
        logic [15:0] lv;
        logic        e_tick;
        logic        e_busy;
        logic        e_exp;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt[$];

    // Behavioural model: timer described by its observable rules only
    logic        m_prev, m_tick, m_busy, m_expire, m_periodic;
    int unsigned m_count, m_reload;

    task automatic model_reset();
        m_prev = 0; m_tick = 0; m_busy = 0; m_expire = 0;
        m_periodic = 0; m_count = 0; m_reload = 0;
    endtask

    task automatic model_clock(input logic cd, input logic st, input logic sp,
                               input logic [15:0] lv, input logic md);
        logic edge_seen;
        edge_seen = cd && !m_prev;
        m_prev    = cd;
        m_tick    = edge_seen;
        m_expire  = 0;
        if (sp) begin
            m_busy = 0; m_count = 0;
        end else if (st) begin
            if (lv == 0) begin
                m_expire = 1; m_busy = 0; m_count = 0;
            end else begin
                m_busy = 1; m_count = lv; m_reload = lv; m_periodic = md;
            end
        end else if (m_busy && edge_seen) begin
            if (m_count == 1) begin
                m_expire = 1;
                if (m_periodic) m_count = m_reload;
                else begin m_busy = 0; m_count = 0; end
            end else begin
                m_count = m_count - 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".tick"},   32'(tif.tick),   32'(m_tick));
        chk({tag, ".busy"},   32'(tif.busy),   32'(m_busy));
        chk({tag, ".expire"}, 32'(tif.expire), 32'(m_expire));
        chk({tag, ".count"},  32'(tif.count),  m_count);
    endtask

    // Drive one cycle of inputs, advance model and DUT, sample 1 time unit after the edge
    task automatic step(input logic cd, input logic st, input logic sp,
                        input logic [15:0] lv, input logic md);
        tif.clk_divided = cd;
        tif.start       = st;
        tif.stop        = sp;
        tif.load_value  = lv;
        tif.mode        = md;
        model_clock(cd, st, sp, lv, md);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic cd, logic st, logic sp, logic md, logic [15:0] lv,
                                logic t, logic b, logic e, logic [15:0] c);
        vec_t v;
        v.cd = cd; v.st = st; v.sp = sp; v.md = md; v.lv = lv;
        v.e_tick = t; v.e_busy = b; v.e_exp = e; v.e_cnt = c;
        return v;
    endfunction

    logic [1:0] div_ph = 2'd0;
    function automatic logic div_next();
        div_ph = div_ph + 2'd1;
        return div_ph[1];
    endfunction

    initial begin
        int n_tick, n_exp, last_exp, bound;
        logic cd;

        // one-shot L=3 on manually paced edges, then zero-load, stop-on-terminal, restart-on-terminal, stop+start in IDLE
        vt.push_back(mk(0,1,0,0,16'd3, 0,1,0,16'd3));
        vt.push_back(mk(1,0,0,0,16'd0, 1,1,0,16'd2));
        vt.push_back(mk(1,0,0,0,16'd0, 0,1,0,16'd2));
        vt.push_back(mk(0,0,0,0,16'd0, 0,1,0,16'd2));
        vt.push_back(mk(0,0,0,0,16'd0, 0,1,0,16'd2));
        vt.push_back(mk(1,0,0,0,16'd0, 1,1,0,16'd1));
        vt.push_back(mk(1,0,0,0,16'd0, 0,1,0,16'd1));
        vt.push_back(mk(0,0,0,0,16'd0, 0,1,0,16'd1));
        vt.push_back(mk(0,0,0,0,16'd0, 0,1,0,16'd1));
        vt.push_back(mk(1,0,0,0,16'd0, 1,0,1,16'd0));
        vt.push_back(mk(1,0,0,0,16'd0, 0,0,0,16'd0));
        vt.push_back(mk(0,0,0,0,16'd0, 0,0,0,16'd0));
        vt.push_back(mk(0,0,0,0,16'd0, 0,0,0,16'd0));
        vt.push_back(mk(1,0,0,0,16'd0, 1,0,0,16'd0));
        vt.push_back(mk(1,1,0,0,16'd0, 0,0,1,16'd0));
        vt.push_back(mk(0,0,0,0,16'd0, 0,0,0,16'd0));
        vt.push_back(mk(0,1,0,0,16'd1, 0,1,0,16'd1));
        vt.push_back(mk(1,0,1,0,16'd0, 1,0,0,16'd0));
        vt.push_back(mk(1,0,0,0,16'd0, 0,0,0,16'd0));
        vt.push_back(mk(0,1,0,1,16'd1, 0,1,0,16'd1));
        vt.push_back(mk(1,1,0,0,16'd5, 1,1,0,16'd5));
        vt.push_back(mk(0,0,0,0,16'd0, 0,1,0,16'd5));
        vt.push_back(mk(0,0,1,0,16'd0, 0,0,0,16'd0));
        vt.push_back(mk(0,1,1,0,16'd7, 0,0,0,16'd0));
        vt.push_back(mk(0,0,0,0,16'd0, 0,0,0,16'd0));

        tif.clk_divided = 0; tif.start = 0; tif.stop = 0;
        tif.load_value = '0; tif.mode = 0;
        model_reset();
        #2;
        chk("reset.tick",   32'(tif.tick),   0);
        chk("reset.busy",   32'(tif.busy),   0);
        chk("reset.expire", 32'(tif.expire), 0);
        chk("reset.count",  32'(tif.count),  0);
        @(posedge clk); #1;
        rst = 1;

        foreach (vt[i]) begin
            step(vt[i].cd, vt[i].st, vt[i].sp, vt[i].lv, vt[i].md);
            chk($sformatf("vec%0d.tick", i),   32'(tif.tick),   32'(vt[i].e_tick));
            chk($sformatf("vec%0d.busy", i),   32'(tif.busy),   32'(vt[i].e_busy));
            chk($sformatf("vec%0d.expire", i), 32'(tif.expire), 32'(vt[i].e_exp));
            chk($sformatf("vec%0d.count", i),  32'(tif.count),  32'(vt[i].e_cnt));
        end

        // free-running divider, no start: one-cycle tick every 4 cycles
        div_ph = 2'd0;
        n_tick = 0;
        for (int c = 0; c < 16; c++) begin
            step(div_next(), 0, 0, 16'd0, 0);
            chk_model("idle_div");
            if (tif.tick) n_tick++;
        end
        chk("idle_div.tick_count", 32'(n_tick), 32'd4);

        // periodic L=2: expire every 8 cycles, busy held
        step(div_next(), 1, 0, 16'd2, 1);
        chk_model("per.start");
        n_exp = 0; last_exp = -1;
        for (int c = 0; c < 40; c++) begin
            step(div_next(), 0, 0, 16'd0, 0);
            chk_model("per");
            chk("per.busy_held", 32'(tif.busy), 1);
            if (tif.expire) begin
                chk("per.count_at_expire", 32'(tif.count), 2);
                if (last_exp >= 0) chk("per.interval", 32'(c - last_exp), 8);
                last_exp = c;
                n_exp++;
            end
        end
        chk("per.min_expires", 32'(n_exp >= 4), 1);
        step(div_next(), 0, 1, 16'd0, 0);
        chk_model("per.stop");

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 31) == 0),
                 16'($urandom_range(0, 5)),
                 1'($urandom_range(0, 1)));
            chk_model("rand");
        end
        step(0, 0, 1, 16'd0, 0);

        // async reset mid-run with count=4 in periodic mode
        div_ph = 2'd0;
        step(div_next(), 1, 0, 16'd6, 1);
        bound = 0;
        while (m_count != 4 && bound < 100) begin
            step(div_next(), 0, 0, 16'd0, 0);
            bound++;
        end
        chk("rstmid.reached", 32'(bound < 100), 1);
        chk_model("rstmid.pre");
        tif.clk_divided = 1;
        #2;
        rst = 0;
        model_reset();
        #1;
        chk("rstmid.tick",   32'(tif.tick),   0);
        chk("rstmid.busy",   32'(tif.busy),   0);
        chk("rstmid.expire", 32'(tif.expire), 0);
        chk("rstmid.count",  32'(tif.count),  0);
        @(posedge clk); #1;
        rst = 1;
        step(1, 0, 0, 16'd0, 0);
        chk("rstrel.first_tick", 32'(tif.tick), 1);
        chk_model("rstrel.first");
        for (int c = 0; c < 12; c++) begin
            step(div_next(), 0, 0, 16'd0, 0);
            chk("rstrel.busy", 32'(tif.busy), 0);
            chk_model("rstrel");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule
